// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control of a word-addressed PC
// with stall, halt/resume, jump/branch redirect and retired/redirect counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             go,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      pc,
    output logic             pc_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // S_IDLE: waiting for start | S_RUN: fetching | S_HALT: waiting for go
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_pc_inc;
    logic             w_pc_en;
    logic             w_retire;
    logic             w_redirect;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_redirect;

    assign w_pc_inc = r_pc + 32'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pc_en     = 1'b0;
        w_retire    = 1'b0;
        w_redirect  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    w_retire = 1'b1;
                    if (halt) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_en    = 1'b1;
                        w_redirect = jump | branch_taken;
                        if (jump) begin
                            w_pc_nxt = jump_target;
                        end else if (branch_taken) begin
                            w_pc_nxt = branch_target;
                        end else begin
                            w_pc_nxt = w_pc_inc;
                        end
                    end
                end
            end
            S_HALT: begin
                if (go) begin
                    w_state_nxt = S_RUN;
                    w_pc_en     = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_retired  <= '0;
            r_redirect <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_retire) begin
                r_retired <= r_retired + CNT_ONE;
            end
            if (w_redirect) begin
                r_redirect <= r_redirect + CNT_ONE;
            end
        end
    end

    // pc_en is a next-edge indicator, so it must drop the moment rst rises
    assign pc_en        = w_pc_en & ~rst;
    assign pc           = r_pc;
    assign running      = (r_state == S_RUN);
    assign halted       = (r_state == S_HALT);
    assign retired_cnt  = r_retired;
    assign redirect_cnt = r_redirect;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main run, then
// hand-written sequences for asynchronous reset and IDLE behaviour.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        halt;
    logic        go;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        pc_en;
    logic        running;
    logic        halted;
    logic [31:0] retired_cnt;
    logic [31:0] redirect_cnt;

    int n_checks = 0;
    int n_err    = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .halt          (halt),
        .go            (go),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_en         (pc_en),
        .running       (running),
        .halted        (halted),
        .retired_cnt   (retired_cnt),
        .redirect_cnt  (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        sl;
        logic        ht;
        logic        g;
        logic        j;
        logic [31:0] jt;
        logic        b;
        logic [31:0] bt;
        logic        e_en;
        logic [31:0] e_pc;
        logic        e_run;
        logic        e_hlt;
        logic [31:0] e_ret;
        logic [31:0] e_red;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic st, input logic sl, input logic ht,
                                input logic g, input logic j, input logic [31:0] jt,
                                input logic b, input logic [31:0] bt,
                                input logic e_en, input logic [31:0] e_pc,
                                input logic e_run, input logic e_hlt,
                                input logic [31:0] e_ret, input logic [31:0] e_red);
        vec_t v;
        v.st = st; v.sl = sl; v.ht = ht; v.g = g; v.j = j; v.jt = jt;
        v.b = b; v.bt = bt; v.e_en = e_en; v.e_pc = e_pc; v.e_run = e_run;
        v.e_hlt = e_hlt; v.e_ret = e_ret; v.e_red = e_red;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic ht, input logic g,
                         input logic j, input logic [31:0] jt, input logic b,
                         input logic [31:0] bt);
        start = st; stall = sl; halt = ht; go = g;
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_run,
                             input logic e_hlt, input logic [31:0] e_ret,
                             input logic [31:0] e_red);
        chk({tag, " pc"}, pc, e_pc);
        chk({tag, " running"}, {31'd0, running}, {31'd0, e_run});
        chk({tag, " halted"}, {31'd0, halted}, {31'd0, e_hlt});
        chk({tag, " retired"}, retired_cnt, e_ret);
        chk({tag, " redirect"}, redirect_cnt, e_red);
    endtask

    initial begin
        //            st sl ht g  j  jt            b  bt            en pc            run hlt ret red
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0,  0,  0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h1,        1, 0,  1,  0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h2,        1, 0,  2,  0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h3,        1, 0,  3,  0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        1, 0,  4,  0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h5,        1, 0,  5,  0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h7,        1, 32'h7,        1, 0,  6,  1);
        vecs[7]  = mk(0, 1, 1, 0, 1, 32'h99,       0, 32'h0,        0, 32'h7,        1, 0,  6,  1);
        vecs[8]  = mk(0, 1, 1, 0, 1, 32'h99,       0, 32'h0,        0, 32'h7,        1, 0,  6,  1);
        vecs[9]  = mk(0, 1, 1, 0, 1, 32'h99,       0, 32'h0,        0, 32'h7,        1, 0,  6,  1);
        vecs[10] = mk(0, 0, 0, 0, 1, 32'h3,        1, 32'h80,       1, 32'h3,        1, 0,  7,  2);
        vecs[11] = mk(0, 0, 0, 0, 1, 32'h40,       1, 32'h80,       1, 32'h40,       1, 0,  8,  3);
        vecs[12] = mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h9,        1, 32'h9,        1, 0,  9,  4);
        vecs[13] = mk(0, 0, 1, 0, 1, 32'h55,       1, 32'h66,       0, 32'h9,        0, 1, 10,  4);
        vecs[14] = mk(1, 0, 0, 0, 1, 32'h55,       0, 32'h0,        0, 32'h9,        0, 1, 10,  4);
        vecs[15] = mk(1, 0, 0, 0, 1, 32'h55,       0, 32'h0,        0, 32'h9,        0, 1, 10,  4);
        vecs[16] = mk(1, 0, 0, 0, 1, 32'h55,       0, 32'h0,        0, 32'h9,        0, 1, 10,  4);
        vecs[17] = mk(1, 0, 0, 0, 1, 32'h55,       0, 32'h0,        0, 32'h9,        0, 1, 10,  4);
        vecs[18] = mk(0, 0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hA,        1, 0, 10,  4);
        vecs[19] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFF,0, 32'h0,        1, 32'hFFFF_FFFF,1, 0, 11,  5);
        vecs[20] = mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 12,  5);
        vecs[21] = mk(0, 0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h1,        1, 0, 13,  5);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk_state("reset", 32'h0, 0, 0, 0, 0);
        chk("reset pc_en", {31'd0, pc_en}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_state("idle", 32'h0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].st, vecs[i].sl, vecs[i].ht, vecs[i].g,
                  vecs[i].j, vecs[i].jt, vecs[i].b, vecs[i].bt);
            #1;
            chk($sformatf("v%0d pc_en", i), {31'd0, pc_en}, {31'd0, vecs[i].e_en});
            @(posedge clk); #1;
            chk_state($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_run,
                      vecs[i].e_hlt, vecs[i].e_ret, vecs[i].e_red);
        end

        // Enter HALT, then assert rst between edges with go pending
        drive(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk_state("halt2", 32'h1, 0, 1, 14, 5);
        drive(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_state("async rst", 32'h0, 0, 0, 0, 0);
        chk("async rst pc_en", {31'd0, pc_en}, 32'd0);
        drive(1, 0, 0, 1, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk_state("held rst", 32'h0, 0, 0, 0, 0);
        rst = 1'b0;

        // IDLE ignores everything but start
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 1, 1, 32'h123, 1, 32'h456);
            #1;
            chk($sformatf("idle%0d pc_en", k), {31'd0, pc_en}, 32'd0);
            @(posedge clk); #1;
            chk_state($sformatf("idle%0d", k), 32'h0, 0, 0, 0, 0);
        end
        drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk_state("restart", 32'h0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk_state("restart run", 32'h1, 1, 0, 1, 0);

        // Reset during a stall discards the pending instruction
        drive(0, 1, 0, 0, 1, 32'h77, 0, 32'h0);
        @(posedge clk); #1;
        chk_state("stall", 32'h1, 1, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_state("stall rst", 32'h0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk_state("post stall rst", 32'h0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
